reverse_index_sched: RTL
========================

Name: reverse_index_sched

Overview:
- Round-robin scheduler that shares one u32 state-memory port between NUM_REQ requesters issuing reverse-index (scatter) commands: mem[arr + index] <= mem[dest], gated by a per-command condition bit.
- Sits between the lcisc issue stage and the exe_env u32 word memory.
- Two-phase pipeline (read source, write target) sustaining one command per cycle, with read-after-write forwarding.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, u32 word-address width of the state memory.
- IDX_W, 32, width of the index operand.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  command valid per requester.
- req_ready  out  NUM_REQ  command accepted (one-hot or zero), combinational.
- req_arr  in  NUM_REQ*ADDR_W  array base address, requester i at slice i.
- req_index  in  NUM_REQ*IDX_W  index value (already resolved immediate/register).
- req_dest  in  NUM_REQ*ADDR_W  source word address.
- req_cond  in  NUM_REQ  pre-evaluated condition; 0 means skip.
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  32  read data, valid the cycle after mem_rd_en.
- mem_wr_en, mem_wr_addr, mem_wr_data  out  1/ADDR_W/32  write port, written at clock edge.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  $clog2(NUM_REQ)  requester of completed command.
- done_skipped  out  1  completed command was skipped.
- exec_count, skip_count  out  CNT_W each  saturating statistics.
- busy  out  1  command in write-back phase.

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr pointer 0, all outputs 0, counters 0, forwarding cleared. Reset mid-operation drops the in-flight command: no write, no done.
- States:
  - IDLE: no command in flight.
  - WB: write-back of the previous accepted executed command.
- Accept: a command is accepted in IDLE or WB when any req_valid is set.
  - Grant goes to the first valid requester at or after the rr pointer, wrapping.
  - req_ready[g] is set that cycle; the pointer becomes (g+1) mod NUM_REQ at the next edge.
  - One acceptance per cycle, in both IDLE and WB.
- Accepted cmd with req_cond=1:
  - mem_rd_en=1, mem_rd_addr=dest in the acceptance cycle.
  - Register wb_addr = (arr + index) mod 2^ADDR_W: zero-extend arr to IDX_W, add, keep low ADDR_W bits.
  - Next state WB.
- Accepted cmd with req_cond=0: no memory access. Next cycle done_valid=1, done_skipped=1, done_id=g, skip_count++. Next state IDLE.
- WB cycle:
  - mem_wr_en=1, mem_wr_addr=wb_addr.
  - mem_wr_data = fwd_hit ? fwd_data : mem_rd_data.
  - done_valid=1, done_skipped=0, done_id of that command, exec_count++, busy=1.
  - Next state WB if a cond=1 command is accepted this cycle, else IDLE.
- Forwarding: if a read is issued in a WB cycle with mem_rd_addr == mem_wr_addr, set fwd_hit and capture fwd_data = current mem_wr_data for the next WB. The memory is read-old-during-write.
- Latency: done one cycle after acceptance for all commands. Throughput is 1 per cycle.
- Counters saturate at 2^CNT_W-1.
- No valid requester: req_ready=0, pointer unchanged.
- Requester deasserting valid before ready: no effect.

Test Plan:
- Reset, mem[5]=0xDEADBEEF, req0 {arr=0x10, index=3, dest=5, cond=1} -> rd_en @ addr 5 in cycle 0; cycle 1 wr_en addr 0x13 data 0xDEADBEEF, done_valid, done_id=0, exec_count=1.
- All 4 requesters valid continuously with cond=1 -> grants 0,1,2,3,0 in consecutive cycles, one write per cycle, done_id follows the same order.
- Back-to-back chain:
  - cmd A {arr=0x20, index=0, dest=1} (mem[1]=0x11).
  - next cycle cmd B {arr=0x30, index=0, dest=0x20}.
  - Expected: mem[0x30]=0x11 via forwarding, not the stale mem[0x20].
- req2 cond=0 -> no rd/wr strobes, next cycle done_valid=1, done_skipped=1, done_id=2, skip_count=1, exec_count unchanged.
- Wrap: arr=0xF0, index=0x0000_0115 with ADDR_W=8 -> write address 0x05.
- rst_n low in the cycle after an accepted cond=1 cmd (async, mid-cycle) -> mem_wr_en and done_valid drop immediately and no write occurs. After release the first grant goes to req0.

Source files
------------

// File: rtl/reverse_index_sched.sv
// rtl/reverse_index_sched.sv - round-robin scheduler for reverse-index scatter commands on one u32 memory port
// Two-phase pipeline: read mem[dest] on accept, write mem[arr+index] next cycle, with RAW forwarding.
module reverse_index_sched #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int IDX_W   = 32,
    parameter int CNT_W   = 16,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_arr,
    input  logic [NUM_REQ*IDX_W-1:0]  req_index,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ-1:0]        req_cond,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [31:0]               mem_rd_data,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [31:0]               mem_wr_data,
    output logic                      done_valid,
    output logic [ID_W-1:0]           done_id,
    output logic                      done_skipped,
    output logic [CNT_W-1:0]          exec_count,
    output logic [CNT_W-1:0]          skip_count,
    output logic                      busy
);

    typedef enum logic {S_IDLE = 1'b0, S_WB = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d, id_q, id_d, grant;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic              skip_q, skip_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [31:0]       fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0]  exec_q, exec_d, skipc_q, skipc_d;
    logic              found, accept, g_cond;
    logic [ADDR_W-1:0] g_arr, g_dest;
    logic [IDX_W-1:0]  g_index;
    logic [31:0]       wb_data;
    int                j;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        found = 1'b0;
        grant = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                grant = ID_W'(j);
            end
        end
    end

    assign accept  = found & rst_n;
    assign g_arr   = req_arr[grant*ADDR_W +: ADDR_W];
    assign g_dest  = req_dest[grant*ADDR_W +: ADDR_W];
    assign g_index = req_index[grant*IDX_W +: IDX_W];
    assign g_cond  = req_cond[grant];
    assign wb_data = fwd_hit_q ? fwd_data_q : mem_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            id_q       <= '0;
            wb_addr_q  <= '0;
            skip_q     <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            exec_q     <= '0;
            skipc_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            wb_addr_q  <= wb_addr_d;
            skip_q     <= skip_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
            exec_q     <= exec_d;
            skipc_q    <= skipc_d;
        end
    end

    // Counters advance at acceptance so they line up with the done pulse.
    always_comb begin
        state_d    = S_IDLE;
        rr_d       = rr_q;
        id_d       = id_q;
        wb_addr_d  = wb_addr_q;
        skip_d     = 1'b0;
        fwd_hit_d  = 1'b0;
        fwd_data_d = fwd_data_q;
        exec_d     = exec_q;
        skipc_d    = skipc_q;
        if (accept) begin
            rr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            id_d = grant;
            if (g_cond) begin
                state_d   = S_WB;
                wb_addr_d = ADDR_W'(IDX_W'(g_arr) + g_index);
                exec_d    = (exec_q == '1) ? exec_q : exec_q + 1'b1;
                // Memory returns old data when read and written at the same edge.
                if (state_q == S_WB && g_dest == wb_addr_q) begin
                    fwd_hit_d  = 1'b1;
                    fwd_data_d = wb_data;
                end
            end else begin
                skip_d  = 1'b1;
                skipc_d = (skipc_q == '1) ? skipc_q : skipc_q + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        mem_rd_en    = accept & g_cond;
        mem_rd_addr  = (accept & g_cond) ? g_dest : '0;
        mem_wr_en    = (state_q == S_WB);
        mem_wr_addr  = (state_q == S_WB) ? wb_addr_q : '0;
        mem_wr_data  = (state_q == S_WB) ? wb_data : '0;
        done_valid   = (state_q == S_WB) | skip_q;
        done_id      = ((state_q == S_WB) | skip_q) ? id_q : '0;
        done_skipped = skip_q;
        busy         = (state_q == S_WB);
        exec_count   = exec_q;
        skip_count   = skipc_q;
    end

endmodule
